// File: rtl/sa_pkg.sv
// sa_pkg: shared types, defaults and the Keff clamp for the systolic operand feeder.
package sa_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE, LOAD, FULL, STREAM} state_t;
  function automatic int clamp_k(input int k, input int depth);
    return (k < 1) ? 1 : ((k > depth) ? depth : k);
  endfunction
endpackage

// File: rtl/sa_skew_feeder_if.sv
// sa_skew_feeder_if: load/stream bus of the operand feeder; replay exists only with SA_FEEDER_REPLAY_EN.
interface sa_skew_feeder_if
  import sa_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LANES      = 4,
  parameter int DEPTH      = 16,
  parameter int K_W        = $clog2(DEPTH + 1)
) ();
  logic                          load_start;
  logic [K_W-1:0]                k_len;
  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_WIDTH-1:0]         in_data;
  logic                          start_compute;
  logic [LANES*DATA_WIDTH-1:0]   lane_data;
  logic [LANES-1:0]              lane_valid;
  logic                          loaded;
  logic                          busy;
  logic                          done;
`ifdef SA_FEEDER_REPLAY_EN
  logic                          replay;
`endif
  modport slave (
`ifdef SA_FEEDER_REPLAY_EN
    input replay,
`endif
    input load_start, k_len, in_valid, in_data, start_compute,
    output in_ready, lane_data, lane_valid, loaded, busy, done
  );
  modport master (
`ifdef SA_FEEDER_REPLAY_EN
    output replay,
`endif
    output load_start, k_len, in_valid, in_data, start_compute,
    input in_ready, lane_data, lane_valid, loaded, busy, done
  );
endinterface

// File: rtl/sa_lane_mem.sv
// sa_lane_mem: per-lane operand store with synchronous write and registered read.
module sa_lane_mem
  import sa_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/sa_skew_feeder.sv
// sa_skew_feeder: loads a lane-major operand matrix, then streams all lanes in systolic skew.
// Define SA_FEEDER_REPLAY_EN to add a replay input that re-streams the last completed load.
module sa_skew_feeder
  import sa_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LANES      = 4,
  parameter int DEPTH      = 16,
  parameter int K_W        = $clog2(DEPTH + 1)
) (
  input logic              clk,
  input logic              rst_n,
  sa_skew_feeder_if.slave  bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = $clog2(LANES);
  localparam int T_W = $clog2(DEPTH + LANES);
  state_t                      r_state;
  logic [K_W-1:0]              r_keff;
  logic [AW-1:0]               r_elem;
  logic [LW-1:0]               r_lane;
  logic [T_W-1:0]              r_t;
  logic                        r_in_ready, r_loaded, r_busy, r_done;
  logic [LANES-1:0]            r_lane_valid, w_lane_valid;
  logic [DATA_WIDTH-1:0]       w_rdata [LANES];
  logic [LANES*DATA_WIDTH-1:0] w_lane_data;
  logic                        w_we, w_elem_wrap, w_last_beat, w_replay;
  assign w_we        = r_in_ready && bus.in_valid;
  assign w_elem_wrap = int'(r_elem) == int'(r_keff) - 1;
  assign w_last_beat = w_elem_wrap && int'(r_lane) == LANES - 1;
`ifdef SA_FEEDER_REPLAY_EN
  logic r_stored;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stored <= 1'b0;
    else if (r_state == IDLE && bus.load_start) r_stored <= 1'b0;
    else if (w_we && w_last_beat) r_stored <= 1'b1;
  end
  assign w_replay = bus.replay && r_stored;
`else
  assign w_replay = 1'b0;
`endif
  // t counts one past the last skew slot so the final lanes drain before done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_keff       <= '0;
      r_elem       <= '0;
      r_lane       <= '0;
      r_t          <= '0;
      r_in_ready   <= 1'b0;
      r_loaded     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_lane_valid <= '0;
    end else begin
      r_done       <= 1'b0;
      r_lane_valid <= w_lane_valid;
      case (r_state)
        IDLE:
          if (bus.load_start) begin
            r_state    <= LOAD;
            r_keff     <= K_W'(clamp_k(int'(bus.k_len), DEPTH));
            r_elem     <= '0;
            r_lane     <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end else if (w_replay) begin
            r_state <= STREAM;
            r_t     <= '0;
            r_busy  <= 1'b1;
          end
        LOAD:
          if (w_we) begin
            r_elem <= w_elem_wrap ? '0 : r_elem + 1'b1;
            r_lane <= w_elem_wrap ? r_lane + 1'b1 : r_lane;
            if (w_last_beat) begin
              r_state    <= FULL;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_loaded   <= 1'b1;
            end
          end
        FULL:
          if (bus.start_compute) begin
            r_state  <= STREAM;
            r_t      <= '0;
            r_loaded <= 1'b0;
            r_busy   <= 1'b1;
          end
        default:
          if (int'(r_t) == int'(r_keff) + LANES - 1) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else r_t <= r_t + 1'b1;
      endcase
    end
  end
  always_comb begin
    w_lane_valid = '0;
    w_lane_data  = '0;
    for (int i = 0; i < LANES; i++) begin
      w_lane_valid[i] = r_state == STREAM && int'(r_t) >= i && int'(r_t) - i < int'(r_keff);
      w_lane_data[i*DATA_WIDTH +: DATA_WIDTH] = r_lane_valid[i] ? w_rdata[i] : '0;
    end
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sa_lane_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk     (clk),
      .i_we    (w_we && int'(r_lane) == i),
      .i_waddr (r_elem),
      .i_wdata (bus.in_data),
      .i_raddr (AW'(int'(r_t) - i)),
      .o_rdata (w_rdata[i])
    );
  end
  assign bus.in_ready   = r_in_ready;
  assign bus.lane_data  = w_lane_data;
  assign bus.lane_valid = r_lane_valid;
  assign bus.loaded     = r_loaded;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
endmodule

// File: tb/tb_sa_skew_feeder.sv
// tb_sa_skew_feeder: directed stimulus with a beat-level reference model checked every cycle.
module tb_sa_skew_feeder;
  localparam int DW = 8, L = 4, D = 16, KW = $clog2(D + 1);
  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;
  sa_skew_feeder_if #(.DATA_WIDTH(DW), .LANES(L), .DEPTH(D)) bus ();
  sa_skew_feeder #(.DATA_WIDTH(DW), .LANES(L), .DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0, errors = 0, acc = 0, ld_base = 0;
  bit chk_en = 0;
  logic [L*DW-1:0] cap_q[$], ref_q[$];
  // reference model: matrix held as accepted beats, stream as a cycle count since start
  logic [DW-1:0] m_mem [L][D];
  int m_mode = 0, m_keff = 1, m_beats = 0, m_cyc = 0;
  bit m_stored = 0, m_done = 0;
  logic e_in_ready = 0, e_loaded = 0, e_busy = 0, e_done = 0;
  logic [L-1:0] e_lv = '0;
  logic [L*DW-1:0] e_ld = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_cyc = 0; m_stored = 0; m_done = 0;
    end else begin
      m_done = 0;
      case (m_mode)
        0: if (bus.load_start) begin
             m_mode = 1; m_beats = 0; m_stored = 0;
             m_keff = (bus.k_len == 0) ? 1 : ((int'(bus.k_len) > D) ? D : int'(bus.k_len));
           end
`ifdef SA_FEEDER_REPLAY_EN
           else if (bus.replay && m_stored) begin m_mode = 3; m_cyc = 0; end
`endif
        1: if (bus.in_valid) begin
             m_mem[m_beats / m_keff][m_beats % m_keff] = bus.in_data;
             m_beats++;
             if (m_beats == L * m_keff) begin m_mode = 2; m_stored = 1; end
           end
        2: if (bus.start_compute) begin m_mode = 3; m_cyc = 0; end
        default: begin
             m_cyc++;
             if (m_cyc == m_keff + L) begin m_mode = 0; m_done = 1; end
           end
      endcase
    end
    e_in_ready = m_mode == 1;
    e_loaded = m_mode == 2;
    e_busy = m_mode == 1 || m_mode == 3;
    e_done = m_done;
    e_lv = '0;
    e_ld = '0;
    if (m_mode == 3 && m_cyc >= 1)
      for (int i = 0; i < L; i++)
        if (m_cyc - 1 - i >= 0 && m_cyc - 1 - i < m_keff) begin
          e_lv[i] = 1'b1;
          e_ld[i*DW +: DW] = m_mem[i][m_cyc - 1 - i];
        end
  end
  always @(posedge clk) if (rst_n && bus.in_valid && bus.in_ready) acc++;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      chk("ctrl", {bus.in_ready, bus.loaded, bus.busy, bus.done}, {e_in_ready, e_loaded, e_busy, e_done});
      chk("lane_valid", bus.lane_valid, e_lv);
      chk("lane_data", bus.lane_data, e_ld);
    end
  endtask
  task automatic load(input int k, input bit gap);
    int keff = (k == 0) ? 1 : ((k > D) ? D : k);
    tick();
    bus.load_start = 1'b1;
    bus.k_len = KW'(k);
    tick();
    bus.load_start = 1'b0;
    ld_base = acc;
    for (int c = 0; c < 400 && acc - ld_base < L * keff; c++) begin
      bus.in_valid = !gap || c % 2 == 0;
      bus.start_compute = gap && c == 3;
      bus.in_data = DW'(16 * ((acc - ld_base) / keff) + (acc - ld_base) % keff);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.start_compute = 1'b0;
    chk("load_beats", acc - ld_base, L * keff);
    chk("load_loaded", bus.loaded, 1);
  endtask
  task automatic stream(input int keff, input int mode, input bit use_replay);
    bit seen = 0, late = 0;
    cap_q.delete();
    tick();
`ifdef SA_FEEDER_REPLAY_EN
    if (use_replay) bus.replay = 1'b1; else bus.start_compute = 1'b1;
`else
    if (!use_replay) bus.start_compute = 1'b1;
`endif
    tick();
    bus.start_compute = 1'b0;
`ifdef SA_FEEDER_REPLAY_EN
    bus.replay = 1'b0;
`endif
    for (int k = 1; k <= keff + L + 4 && !seen; k++) begin
      tick();
      cap_q.push_back(bus.lane_data);
      if (mode == 1 && k == 4) chk("t3_lanes", {bus.lane_valid, bus.lane_data}, {4'hf, 32'h30211203});
      if (mode == 1 && k == 7) chk("t6_lane3", {bus.lane_valid, bus.lane_data}, {4'h8, 32'h33000000});
      if (mode == 2 && k <= 4) chk("walk_valid", bus.lane_valid, 64'(1) << (k - 1));
      if (mode == 3 && k == 2) begin
        #2 rst_n = 1'b0;
        #1 chk("async_rst", {bus.in_ready, bus.loaded, bus.busy, bus.done, bus.lane_valid, bus.lane_data}, 0);
        tick();
        #2 rst_n = 1'b1;
        repeat (keff + L) begin
          tick();
          late |= bus.done;
        end
        chk("no_done_after_rst", late, 0);
        return;
      end
      if (bus.done) begin
        seen = 1;
        chk("done_cycle", k, keff + L);
      end
    end
    chk("done_seen", seen, 1);
  endtask
  initial begin
    bus.load_start = 0; bus.k_len = '0; bus.in_valid = 0; bus.in_data = '0; bus.start_compute = 0;
`ifdef SA_FEEDER_REPLAY_EN
    bus.replay = 0;
`endif
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("reset_outs", {bus.in_ready, bus.loaded, bus.busy, bus.done, bus.lane_valid, bus.lane_data}, 0);
    #2 rst_n = 1'b1;
`ifdef SA_FEEDER_REPLAY_EN
    tick();
    bus.replay = 1'b1;
    tick();
    bus.replay = 1'b0;
    chk("replay_ignored", bus.busy, 0);
`endif
    load(4, 0);
    stream(4, 1, 0);
    load(0, 0);
    stream(1, 2, 0);
    load(20, 0);
    bus.in_valid = 1'b1;
    bus.in_data = 8'hee;
    repeat (2) tick();
    bus.in_valid = 1'b0;
    chk("overflow_beats", acc - ld_base, 64);
    chk("overflow_state", {bus.in_ready, bus.loaded}, 2'b01);
    stream(16, 0, 0);
    load(4, 1);
    stream(4, 0, 0);
    load(4, 0);
    stream(4, 3, 0);
    load(2, 0);
    stream(2, 0, 0);
`ifdef SA_FEEDER_REPLAY_EN
    load(3, 0);
    stream(3, 0, 0);
    ref_q = cap_q;
    stream(3, 0, 1);
    chk("replay_len", cap_q.size(), ref_q.size());
    for (int i = 0; i < ref_q.size() && i < cap_q.size(); i++) chk("replay_seq", cap_q[i], ref_q[i]);
`endif
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
